// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the two-requester APB arbiter in front of the SPI block.
package spi_arb_pkg;

    localparam int          NUM_REQ         = 2;
    localparam int unsigned DEFAULT_TIMEOUT = 1024;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } arb_state_e;

endpackage

// File: rtl/spi_arb_rr.sv
// Combinational two-way round-robin picker: a contested cycle goes to the requester
// that was not served last, a lone requester always wins.
module spi_arb_rr (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant,
    output logic       valid
);

    always_comb begin
        valid = |req;
        if (req == 2'b11) begin
            grant = ~last_grant;
        end else begin
            grant = req[1];
        end
    end

endmodule

// File: rtl/spi_apb_arbiter.sv
// Two-master APB arbiter: latches the winning request, runs one SETUP/ACCESS transfer
// on the shared slave port and returns the response to the granted master for one cycle.
module spi_apb_arbiter
    import spi_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic        clock,
    input  logic        reset,

    input  logic [31:0] m0_paddr,
    input  logic        m0_psel,
    input  logic        m0_penable,
    input  logic        m0_pwrite,
    input  logic [31:0] m0_pwdata,
    input  logic [3:0]  m0_pstrb,
    output logic        m0_pready,
    output logic [31:0] m0_prdata,
    output logic        m0_pslverr,

    input  logic [31:0] m1_paddr,
    input  logic        m1_psel,
    input  logic        m1_penable,
    input  logic        m1_pwrite,
    input  logic [31:0] m1_pwdata,
    input  logic [3:0]  m1_pstrb,
    output logic        m1_pready,
    output logic [31:0] m1_prdata,
    output logic        m1_pslverr,

    output logic [31:0] s_paddr,
    output logic        s_psel,
    output logic        s_penable,
    output logic        s_pwrite,
    output logic [31:0] s_pwdata,
    output logic [3:0]  s_pstrb,
    input  logic        s_pready,
    input  logic [31:0] s_prdata,
    input  logic        s_pslverr
);

    arb_state_e  state_reg;
    logic        grant_reg;
    logic        last_grant_reg;
    logic [31:0] to_cnt_reg;
    logic [31:0] cap_prdata_reg;
    logic        cap_pslverr_reg;

    logic [31:0] s_paddr_reg;
    logic        s_psel_reg;
    logic        s_penable_reg;
    logic        s_pwrite_reg;
    logic [31:0] s_pwdata_reg;
    logic [3:0]  s_pstrb_reg;

    logic [NUM_REQ-1:0] req;
    logic [31:0]        req_paddr  [NUM_REQ];
    logic               req_pwrite [NUM_REQ];
    logic [31:0]        req_pwdata [NUM_REQ];
    logic [3:0]         req_pstrb  [NUM_REQ];

    logic [NUM_REQ-1:0] rsp_pready;
    logic [31:0]        rsp_prdata [NUM_REQ];
    logic [NUM_REQ-1:0] rsp_pslverr;

    logic pick_grant;
    logic pick_valid;
    logic timeout_hit;
    logic access_done;

    // penable from the masters carries no arbitration information
    logic unused_penable;
    assign unused_penable = m0_penable ^ m1_penable;

    assign req           = {m1_psel, m0_psel};
    assign req_paddr[0]  = m0_paddr;
    assign req_paddr[1]  = m1_paddr;
    assign req_pwrite[0] = m0_pwrite;
    assign req_pwrite[1] = m1_pwrite;
    assign req_pwdata[0] = m0_pwdata;
    assign req_pwdata[1] = m1_pwdata;
    assign req_pstrb[0]  = m0_pstrb;
    assign req_pstrb[1]  = m1_pstrb;

    spi_arb_rr u_rr (
        .req        (req),
        .last_grant (last_grant_reg),
        .grant      (pick_grant),
        .valid      (pick_valid)
    );

    // The counter holds the number of low-pready ACCESS cycles already completed,
    // so the limit is reached during the TIMEOUT_CYCLES-th cycle.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (to_cnt_reg == TIMEOUT_CYCLES - 1);
    assign access_done = s_pready || timeout_hit;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            grant_reg       <= 1'b0;
            last_grant_reg  <= 1'b1;
            to_cnt_reg      <= '0;
            cap_prdata_reg  <= '0;
            cap_pslverr_reg <= 1'b0;
            s_paddr_reg     <= '0;
            s_psel_reg      <= 1'b0;
            s_penable_reg   <= 1'b0;
            s_pwrite_reg    <= 1'b0;
            s_pwdata_reg    <= '0;
            s_pstrb_reg     <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant_reg    <= pick_grant;
                        s_paddr_reg  <= req_paddr[pick_grant];
                        s_pwrite_reg <= req_pwrite[pick_grant];
                        s_pwdata_reg <= req_pwdata[pick_grant];
                        s_pstrb_reg  <= req_pstrb[pick_grant];
                        s_psel_reg   <= 1'b1;
                        state_reg    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    s_penable_reg <= 1'b1;
                    to_cnt_reg    <= '0;
                    state_reg     <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (access_done) begin
                        cap_prdata_reg  <= s_pready ? s_prdata : 32'd0;
                        cap_pslverr_reg <= s_pready ? s_pslverr : 1'b1;
                        s_paddr_reg     <= '0;
                        s_psel_reg      <= 1'b0;
                        s_penable_reg   <= 1'b0;
                        s_pwrite_reg    <= 1'b0;
                        s_pwdata_reg    <= '0;
                        s_pstrb_reg     <= '0;
                        state_reg       <= ST_RESP;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        to_cnt_reg <= to_cnt_reg + 32'd1;
                    end
                end
                ST_RESP: begin
                    last_grant_reg <= grant_reg;
                    state_reg      <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_paddr   = s_paddr_reg;
    assign s_psel    = s_psel_reg;
    assign s_penable = s_penable_reg;
    assign s_pwrite  = s_pwrite_reg;
    assign s_pwdata  = s_pwdata_reg;
    assign s_pstrb   = s_pstrb_reg;

    // Only the served master sees the response; the other stays at zero.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
            logic served;
            assign served          = (state_reg == ST_RESP) && (grant_reg == 1'(gi));
            assign rsp_pready[gi]  = served;
            assign rsp_prdata[gi]  = served ? cap_prdata_reg : 32'd0;
            assign rsp_pslverr[gi] = served & cap_pslverr_reg;
        end
    endgenerate

    assign m0_pready  = rsp_pready[0];
    assign m0_prdata  = rsp_prdata[0];
    assign m0_pslverr = rsp_pslverr[0];
    assign m1_pready  = rsp_pready[1];
    assign m1_prdata  = rsp_prdata[1];
    assign m1_pslverr = rsp_pslverr[1];

endmodule

// File: tb/tb_spi_apb_arbiter.sv
// Directed bench for spi_apb_arbiter: a small APB slave model answers transfers and
// every response returned to a master is logged with its cycle number.
module tb_spi_apb_arbiter;

    localparam logic [31:0] XK = 32'h5A5A5A5A;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] m0_paddr, m1_paddr, m0_pwdata, m1_pwdata;
    logic        m0_psel, m1_psel, m0_penable, m1_penable, m0_pwrite, m1_pwrite;
    logic [3:0]  m0_pstrb, m1_pstrb;
    logic        m0_pready, m1_pready, m0_pslverr, m1_pslverr;
    logic [31:0] m0_prdata, m1_prdata;
    logic [31:0] s_paddr, s_pwdata;
    logic        s_psel, s_penable, s_pwrite;
    logic [3:0]  s_pstrb;
    logic        s_pready  = 1'b0;
    logic [31:0] s_prdata  = 32'd0;
    logic        s_pslverr = 1'b0;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          slave_wait  = 0;
    logic        slave_err   = 1'b0;
    logic        fixed_en    = 1'b0;
    logic [31:0] fixed_rdata = 32'd0;
    logic        hold0 = 1'b0;
    logic        hold1 = 1'b0;

    int          ev_who[$];
    int          ev_cyc[$];
    logic [31:0] ev_data[$];
    logic        ev_err[$];
    logic [31:0] acc_addr[$];
    logic [31:0] acc_wdata[$];
    logic [3:0]  acc_strb[$];

    always #5 clock = ~clock;

    spi_apb_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clock(clock), .reset(reset),
        .m0_paddr(m0_paddr), .m0_psel(m0_psel), .m0_penable(m0_penable),
        .m0_pwrite(m0_pwrite), .m0_pwdata(m0_pwdata), .m0_pstrb(m0_pstrb),
        .m0_pready(m0_pready), .m0_prdata(m0_prdata), .m0_pslverr(m0_pslverr),
        .m1_paddr(m1_paddr), .m1_psel(m1_psel), .m1_penable(m1_penable),
        .m1_pwrite(m1_pwrite), .m1_pwdata(m1_pwdata), .m1_pstrb(m1_pstrb),
        .m1_pready(m1_pready), .m1_prdata(m1_prdata), .m1_pslverr(m1_pslverr),
        .s_paddr(s_paddr), .s_psel(s_psel), .s_penable(s_penable),
        .s_pwrite(s_pwrite), .s_pwdata(s_pwdata), .s_pstrb(s_pstrb),
        .s_pready(s_pready), .s_prdata(s_prdata), .s_pslverr(s_pslverr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    function automatic int who_at(input int i);
        return (i < ev_who.size()) ? ev_who[i] : -1;
    endfunction

    function automatic int cyc_at(input int i);
        return (i < ev_cyc.size()) ? ev_cyc[i] : -1;
    endfunction

    function automatic logic [31:0] data_at(input int i);
        return (i < ev_data.size()) ? ev_data[i] : 32'hBAD0BAD0;
    endfunction

    function automatic logic err_at(input int i);
        return (i < ev_err.size()) ? ev_err[i] : 1'bx;
    endfunction

    // Steps n cycles logging every response; drops a master's psel once served unless held.
    task automatic collect(input int n);
        int leak;
        leak = 0;
        ev_who.delete(); ev_cyc.delete(); ev_data.delete(); ev_err.delete();
        acc_addr.delete(); acc_wdata.delete(); acc_strb.delete();
        for (int i = 0; i < n; i++) begin
            step();
            if (m0_pready && m1_pready) leak++;
            if (!m0_pready && (m0_prdata != 0 || m0_pslverr)) leak++;
            if (!m1_pready && (m1_prdata != 0 || m1_pslverr)) leak++;
            if (m0_pready) begin
                ev_who.push_back(0); ev_cyc.push_back(cyc);
                ev_data.push_back(m0_prdata); ev_err.push_back(m0_pslverr);
                $display("txn m0 cyc %0d prdata %h pslverr %0d", cyc, m0_prdata, m0_pslverr);
                if (!hold0) m0_psel = 1'b0;
            end
            if (m1_pready) begin
                ev_who.push_back(1); ev_cyc.push_back(cyc);
                ev_data.push_back(m1_prdata); ev_err.push_back(m1_pslverr);
                $display("txn m1 cyc %0d prdata %h pslverr %0d", cyc, m1_prdata, m1_pslverr);
                if (!hold1) m1_psel = 1'b0;
            end
        end
        check("unserved_outputs_zero", leak, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // APB slave: pready after slave_wait extra ACCESS cycles, controls must hold steady.
    initial begin : slave_model
        int          acc_n;
        logic [31:0] first_addr, first_wdata;
        acc_n = 0;
        first_addr = 0;
        first_wdata = 0;
        forever begin
            @(posedge clock);
            #1;
            if (s_psel && s_penable) begin
                if (acc_n == 0) begin
                    first_addr  = s_paddr;
                    first_wdata = s_pwdata;
                    acc_addr.push_back(s_paddr);
                    acc_wdata.push_back(s_pwdata);
                    acc_strb.push_back(s_pstrb);
                end else begin
                    check("access_paddr_stable", s_paddr, first_addr);
                    check("access_pwdata_stable", s_pwdata, first_wdata);
                end
                s_pready  = (acc_n == slave_wait);
                s_prdata  = fixed_en ? fixed_rdata : (s_paddr ^ XK);
                s_pslverr = slave_err;
                acc_n++;
            end else begin
                acc_n     = 0;
                s_pready  = 1'b0;
                s_prdata  = 32'd0;
                s_pslverr = 1'b0;
            end
        end
    end

    initial begin : main
        int t0;
        reset = 1'b1;
        m0_paddr = 0; m0_psel = 0; m0_penable = 0; m0_pwrite = 0; m0_pwdata = 0; m0_pstrb = 0;
        m1_paddr = 0; m1_psel = 0; m1_penable = 0; m1_pwrite = 0; m1_pwdata = 0; m1_pstrb = 0;
        do_reset();

        check("reset_ctrl_zero", {20'd0, s_psel, s_penable, s_pwrite, s_pstrb,
                                  m0_pready, m1_pready, m0_pslverr, m1_pslverr, 1'b0}, 32'd0);
        check("reset_data_zero", s_paddr | s_pwdata | m0_prdata | m1_prdata, 32'd0);

        // Single m0 read; slave answers in the third ACCESS cycle.
        slave_wait = 2; fixed_en = 1'b1; fixed_rdata = 32'hDEADBEEF;
        t0 = cyc;
        m0_paddr = 32'h30000100; m0_pwrite = 1'b0; m0_psel = 1'b1;
        step();
        check("setup_psel_penable", {30'd0, s_psel, s_penable}, 32'd2);
        check("setup_paddr", s_paddr, 32'h30000100);
        m0_psel = 1'b0; m0_paddr = 32'hFFFFFFFF;
        step();
        check("access_psel_penable", {30'd0, s_psel, s_penable}, 32'd3);
        check("access_paddr_latched", s_paddr, 32'h30000100);
        collect(5);
        check("single_event_count", ev_who.size(), 1);
        check("single_who", who_at(0), 0);
        check("single_latency", cyc_at(0) - t0, 5);
        check("single_prdata", data_at(0), 32'hDEADBEEF);

        // Simultaneous requests after reset: m0 first, m1 right behind.
        do_reset();
        slave_wait = 0; fixed_en = 1'b0;
        m0_paddr = 32'h30000200; m1_paddr = 32'h10001000;
        t0 = cyc;
        m0_psel = 1'b1; m1_psel = 1'b1;
        collect(10);
        check("pair_event_count", ev_who.size(), 2);
        check("pair_first_who", who_at(0), 0);
        check("pair_first_cyc", cyc_at(0) - t0, 3);
        check("pair_first_prdata", data_at(0), 32'h30000200 ^ XK);
        check("pair_second_who", who_at(1), 1);
        check("pair_second_cyc", cyc_at(1) - t0, 7);
        check("pair_second_prdata", data_at(1), 32'h10001000 ^ XK);
        t0 = cyc;
        m0_psel = 1'b1; m1_psel = 1'b1;
        collect(10);
        check("repeat_first_who", who_at(0), 0);
        check("repeat_first_cyc", cyc_at(0) - t0, 3);

        // m1 write contending with a continuously requesting m0.
        do_reset();
        slave_wait = 2;
        m1_paddr = 32'h10001014; m1_pwrite = 1'b1; m1_pwdata = 32'h4; m1_pstrb = 4'hF;
        m0_paddr = 32'h30000300; m0_pwrite = 1'b0; m0_pwdata = 32'h11111111; m0_pstrb = 4'h0;
        t0 = cyc;
        m1_psel = 1'b1;
        step();
        m0_psel = 1'b1; hold0 = 1'b1; hold1 = 1'b1;
        collect(23);
        check("alt_event_count", ev_who.size(), 4);
        check("alt_order", {who_at(0), who_at(1), who_at(2), who_at(3)} == {32'd1, 32'd0, 32'd1, 32'd0}, 32'd1);
        check("alt_first_cyc", cyc_at(0) - t0, 5);
        check("alt_m1_paddr", (acc_addr.size() > 0) ? acc_addr[0] : 32'hBAD0BAD0, 32'h10001014);
        check("alt_m1_pwdata", (acc_wdata.size() > 0) ? acc_wdata[0] : 32'hBAD0BAD0, 32'h4);
        check("alt_m1_pstrb", (acc_strb.size() > 0) ? 32'(acc_strb[0]) : 32'hBAD0BAD0, 32'hF);
        check("alt_m0_paddr", (acc_addr.size() > 1) ? acc_addr[1] : 32'hBAD0BAD0, 32'h30000300);
        hold0 = 1'b0; hold1 = 1'b0; m0_psel = 1'b0; m1_psel = 1'b0;
        m1_pwrite = 1'b0; m1_pwdata = 0; m1_pstrb = 0;
        do_reset();

        // Slave never answers: the 8-cycle timeout produces an error response.
        slave_wait = 100; fixed_en = 1'b1; fixed_rdata = 32'hCAFEF00D;
        m0_paddr = 32'h30000400;
        t0 = cyc;
        m0_psel = 1'b1;
        collect(12);
        check("timeout_event_count", ev_who.size(), 1);
        check("timeout_cyc", cyc_at(0) - t0, 10);
        check("timeout_prdata", data_at(0), 32'd0);
        check("timeout_pslverr", 32'(err_at(0)), 32'd1);
        check("timeout_back_idle", {31'd0, s_psel}, 32'd0);

        // Reset in the middle of ACCESS abandons the transfer.
        m0_psel = 1'b1;
        step(); step(); step();
        m0_psel = 1'b0;
        check("pre_reset_in_access", {30'd0, s_psel, s_penable}, 32'd3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midreset_ctrl_zero", {27'd0, s_psel, s_penable, s_pwrite, m0_pready, m1_pready}, 32'd0);
        check("midreset_data_zero", s_paddr | s_pwdata | m0_prdata | m1_prdata, 32'd0);
        collect(6);
        check("midreset_no_pulse", ev_who.size(), 0);
        slave_wait = 0; fixed_en = 1'b0;
        m1_paddr = 32'h3FFFFFFC;
        t0 = cyc;
        m1_psel = 1'b1;
        collect(6);
        check("postreset_m1_count", ev_who.size(), 1);
        check("postreset_m1_who", who_at(0), 1);
        check("postreset_m1_cyc", cyc_at(0) - t0, 3);
        check("postreset_m1_prdata", data_at(0), 32'h3FFFFFFC ^ XK);

        // Slave error is forwarded for exactly one cycle.
        slave_err = 1'b1;
        m1_paddr = 32'h10001FFC;
        t0 = cyc;
        m1_psel = 1'b1;
        collect(5);
        check("slverr_count", ev_who.size(), 1);
        check("slverr_value", 32'(err_at(0)), 32'd1);
        check("slverr_cleared", {30'd0, m1_pslverr, m1_pready}, 32'd0);
        slave_err = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
